// File: rtl/wdt_service_master.sv
// wdt_service_master: Avalon-MM master that starts, periodically kicks and services the on-chip
// watchdog timer slave.
//
// Sequence: START writes control (start + irq enable). Each service round is a KICK write to
// period_l (forces a reload), a status read, and a CLEAR write when the timeout bit was latched.
//
// Ports:
//   clk, reset      system clock, synchronous active-high reset
//   enable          servicing permitted; low lets the watchdog expire
//   wdt_irq         watchdog interrupt; cuts the current WAIT short
//   avm_*           Avalon-MM master pins driven straight onto the watchdog slave
//   running         bit 1 of the last status read
//   timeout_pulse   one-cycle pulse for each detected timeout (coincides with the CLEAR write)
//   timeout_count   saturating count of detected timeouts
//   kick_count      saturating count of kick writes
//   busy            high whenever the sequencer is not idle
module wdt_service_master #(
  parameter int unsigned KICK_INTERVAL = 100000000,
  parameter int unsigned IRQ_ENABLE    = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        wdt_irq,
  output logic [2:0]  avm_address,
  output logic        avm_chipselect,
  output logic        avm_write_n,
  output logic [15:0] avm_writedata,
  input  logic [15:0] avm_readdata,
  output logic        running,
  output logic        timeout_pulse,
  output logic [7:0]  timeout_count,
  output logic [15:0] kick_count,
  output logic        busy
);

  localparam logic [2:0]  AddrStatus  = 3'd0;
  localparam logic [2:0]  AddrControl = 3'd1;
  localparam logic [2:0]  AddrPeriodL = 3'd2;
  localparam logic [15:0] CtrlStart   = 16'h0004 | {15'd0, IRQ_ENABLE[0]};
  localparam logic [31:0] IntervalLoad = 32'(KICK_INTERVAL - 1);

  typedef enum logic [2:0] {
    StIdle, StStart, StWait, StKick, StRdAddr, StRdData, StClear
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic [2:0]  addr_d;
  logic        cs_d, write_n_d;
  logic [15:0] wdata_d;
  logic        running_d, pulse_d, busy_d;
  logic [7:0]  tcount_d;
  logic [15:0] kcount_d;

  // Only the two status bits carry meaning.
  logic unused_readdata;
  assign unused_readdata = ^avm_readdata[15:2];

  // Next-state logic. KICK/RD_ADDR ignore enable so a started service round always completes.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (enable) state_d = StStart;
      StStart:  state_d = StWait;
      StWait: begin
        if (!enable)                      state_d = StIdle;
        else if (cnt_q == 32'd0 || wdt_irq) state_d = StKick;
      end
      StKick:   state_d = StRdAddr;
      StRdAddr: state_d = StRdData;
      StRdData: begin
        if (avm_readdata[0]) state_d = StClear;
        else if (!enable)    state_d = StIdle;
        else                 state_d = StWait;
      end
      StClear:  state_d = enable ? StWait : StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Outputs are decoded from the next state and registered, so the bus pins change on the
  // same edge as the state.
  always_comb begin
    addr_d    = 3'd0;
    cs_d      = 1'b0;
    write_n_d = 1'b1;
    wdata_d   = 16'h0000;
    unique case (state_d)
      StStart: begin
        addr_d = AddrControl; cs_d = 1'b1; write_n_d = 1'b0; wdata_d = CtrlStart;
      end
      StKick: begin
        addr_d = AddrPeriodL; cs_d = 1'b1; write_n_d = 1'b0;
      end
      StRdAddr: begin
        addr_d = AddrStatus; cs_d = 1'b1;
      end
      StClear: begin
        addr_d = AddrStatus; cs_d = 1'b1; write_n_d = 1'b0;
      end
      default: ;
    endcase
  end

  always_comb begin
    cnt_d = cnt_q;
    if (state_d == StWait && state_q != StWait) begin
      cnt_d = IntervalLoad;
    end else if (state_q == StWait && cnt_q != 32'd0) begin
      cnt_d = cnt_q - 32'd1;
    end

    kcount_d = kick_count;
    if (state_d == StKick && kick_count != 16'hFFFF) kcount_d = kick_count + 16'd1;

    tcount_d = timeout_count;
    if (state_d == StClear && timeout_count != 8'hFF) tcount_d = timeout_count + 8'd1;

    running_d = running;
    if (state_q == StRdData) running_d = avm_readdata[1];

    pulse_d = (state_d == StClear);
    busy_d  = (state_d != StIdle);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= StIdle;
      cnt_q          <= 32'd0;
      avm_address    <= 3'd0;
      avm_chipselect <= 1'b0;
      avm_write_n    <= 1'b1;
      avm_writedata  <= 16'h0000;
      running        <= 1'b0;
      timeout_pulse  <= 1'b0;
      timeout_count  <= 8'd0;
      kick_count     <= 16'd0;
      busy           <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      avm_address    <= addr_d;
      avm_chipselect <= cs_d;
      avm_write_n    <= write_n_d;
      avm_writedata  <= wdata_d;
      running        <= running_d;
      timeout_pulse  <= pulse_d;
      timeout_count  <= tcount_d;
      kick_count     <= kcount_d;
      busy           <= busy_d;
    end
  end

endmodule

// File: tb/tb_wdt_service_master.sv
// Directed bench for wdt_service_master with KICK_INTERVAL = 8. Expected bus transactions
// (kind, address, data, cycle) are queued when stimulus is applied and checked by a bus monitor.
module tb_wdt_service_master;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic        wdt_irq;
  logic [2:0]  avm_address;
  logic        avm_chipselect;
  logic        avm_write_n;
  logic [15:0] avm_writedata;
  logic [15:0] avm_readdata = 16'h0000;
  logic        running;
  logic        timeout_pulse;
  logic [7:0]  timeout_count;
  logic [15:0] kick_count;
  logic        busy;

  logic [15:0] status_reg = 16'h0000;
  int          cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;

  typedef struct {
    bit          wr;
    logic [2:0]  addr;
    logic [15:0] data;
    int          cyc;
  } txn_t;
  txn_t exp_q[$];

  wdt_service_master #(.KICK_INTERVAL(8), .IRQ_ENABLE(1)) dut (
    .clk            (clk),
    .reset          (reset),
    .enable         (enable),
    .wdt_irq        (wdt_irq),
    .avm_address    (avm_address),
    .avm_chipselect (avm_chipselect),
    .avm_write_n    (avm_write_n),
    .avm_writedata  (avm_writedata),
    .avm_readdata   (avm_readdata),
    .running        (running),
    .timeout_pulse  (timeout_pulse),
    .timeout_count  (timeout_count),
    .kick_count     (kick_count),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Watchdog slave read path: registered, valid the cycle after the address.
  always @(posedge clk) begin
    if (avm_chipselect && avm_write_n) avm_readdata <= status_reg;
  end

  // Bus monitor: every chipselect cycle must match the next queued transaction.
  always @(negedge clk) begin
    if (avm_chipselect) begin
      n_checks++;
      assert (exp_q.size() != 0) else begin
        n_fail++;
        $error("FAIL unexpected_txn observed wr=%0d addr=%0d data=%h cyc=%0d expected none",
               !avm_write_n, avm_address, avm_writedata, cyc);
      end
      if (exp_q.size() != 0) begin
        txn_t t;
        logic [19:0] obs, exp;
        t = exp_q.pop_front();
        obs = {!avm_write_n, avm_address, avm_write_n ? 16'h0000 : avm_writedata};
        exp = {t.wr, t.addr, t.wr ? t.data : 16'h0000};
        n_checks++;
        assert (obs === exp) else begin
          n_fail++;
          $error("FAIL txn_content observed %h expected %h (wr,addr,data) at cyc %0d",
                 obs, exp, cyc);
        end
        n_checks++;
        assert (cyc === t.cyc) else begin
          n_fail++;
          $error("FAIL txn_cycle observed %0d expected %0d", cyc, t.cyc);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) tick();
  endtask

  task automatic push(input bit wr, input logic [2:0] addr, input logic [15:0] data,
                      input int c);
    txn_t t;
    t.wr = wr; t.addr = addr; t.data = data; t.cyc = c;
    exp_q.push_back(t);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed %h expected %h at cyc %0d", tag, obs, exp, cyc);
    end
  endtask

  int t0, t1, t2;

  initial begin
    reset = 1'b1;
    enable = 1'b0;
    wdt_irq = 1'b0;
    repeat (3) tick();
    check("rst_cs", 32'(avm_chipselect), 32'd0);
    check("rst_write_n", 32'(avm_write_n), 32'd1);
    check("rst_addr", 32'(avm_address), 32'd0);
    check("rst_wdata", 32'(avm_writedata), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_counts", {8'd0, timeout_count, kick_count}, 32'd0);
    check("rst_flags", {running, timeout_pulse}, 32'd0);
    reset = 1'b0;
    tick();

    // Normal servicing: status 2 (running, no timeout), then 3 (timeout -> CLEAR).
    t0 = cyc;
    enable = 1'b1;
    status_reg = 16'h0002;
    push(1, 3'd1, 16'h0005, t0 + 1);
    push(1, 3'd2, 16'h0000, t0 + 10);
    push(0, 3'd0, 16'h0000, t0 + 11);
    push(1, 3'd2, 16'h0000, t0 + 21);
    push(0, 3'd0, 16'h0000, t0 + 22);
    push(1, 3'd0, 16'h0000, t0 + 24);
    push(1, 3'd2, 16'h0000, t0 + 33);
    push(0, 3'd0, 16'h0000, t0 + 34);
    push(1, 3'd2, 16'h0000, t0 + 39);
    push(0, 3'd0, 16'h0000, t0 + 40);
    push(1, 3'd0, 16'h0000, t0 + 42);
    wait_cyc(t0 + 1);
    check("busy_start", 32'(busy), 32'd1);
    wait_cyc(t0 + 11);
    check("kick_count_1", 32'(kick_count), 32'd1);
    wait_cyc(t0 + 13);
    check("running_1", 32'(running), 32'd1);
    check("tcount_0", 32'(timeout_count), 32'd0);
    check("no_pulse", 32'(timeout_pulse), 32'd0);
    status_reg = 16'h0003;
    wait_cyc(t0 + 22);
    check("kick_count_2", 32'(kick_count), 32'd2);
    wait_cyc(t0 + 24);
    check("pulse_clear", 32'(timeout_pulse), 32'd1);
    status_reg = 16'h0002;
    wait_cyc(t0 + 25);
    check("pulse_one_cycle", 32'(timeout_pulse), 32'd0);
    check("tcount_1", 32'(timeout_count), 32'd1);

    // Irq on the third WAIT cycle forces an early kick.
    wait_cyc(t0 + 38);
    wdt_irq = 1'b1;
    tick();
    wdt_irq = 1'b0;
    status_reg = 16'h0003;
    wait_cyc(t0 + 42);
    check("pulse_irq_clear", 32'(timeout_pulse), 32'd1);
    status_reg = 16'h0002;
    wait_cyc(t0 + 43);
    check("tcount_2", 32'(timeout_count), 32'd2);
    check("kick_count_4", 32'(kick_count), 32'd4);

    // Disable mid-WAIT.
    wait_cyc(t0 + 45);
    enable = 1'b0;
    tick();
    check("dis_wait_busy", 32'(busy), 32'd0);
    check("dis_wait_bus", {avm_chipselect, avm_write_n}, 32'd1);

    // Disable during RD_ADDR: the read completes, then IDLE.
    wait_cyc(t0 + 48);
    t1 = cyc;
    enable = 1'b1;
    push(1, 3'd1, 16'h0005, t1 + 1);
    push(1, 3'd2, 16'h0000, t1 + 10);
    push(0, 3'd0, 16'h0000, t1 + 11);
    wait_cyc(t1 + 11);
    enable = 1'b0;
    wait_cyc(t1 + 12);
    check("rd_data_busy", 32'(busy), 32'd1);
    wait_cyc(t1 + 13);
    check("rd_dis_idle", 32'(busy), 32'd0);
    check("kick_count_5", 32'(kick_count), 32'd5);

    // Reset during a CLEAR write, then re-enable.
    wait_cyc(t1 + 15);
    t2 = cyc;
    enable = 1'b1;
    status_reg = 16'h0003;
    push(1, 3'd1, 16'h0005, t2 + 1);
    push(1, 3'd2, 16'h0000, t2 + 10);
    push(0, 3'd0, 16'h0000, t2 + 11);
    push(1, 3'd0, 16'h0000, t2 + 13);
    wait_cyc(t2 + 13);
    check("pulse_pre_reset", 32'(timeout_pulse), 32'd1);
    reset = 1'b1;
    tick();
    check("midrst_bus", {avm_chipselect, avm_write_n}, 32'd1);
    check("midrst_counts", {8'd0, timeout_count, kick_count}, 32'd0);
    check("midrst_flags", {busy, running, timeout_pulse}, 32'd0);
    reset = 1'b0;
    push(1, 3'd1, 16'h0005, t2 + 15);
    tick();
    enable = 1'b0;
    wait_cyc(t2 + 20);
    check("final_idle", 32'(busy), 32'd0);
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
